spi_rx_fifo: RTL
================

# spi_rx_fifo

Receive buffer between the SPI slave data plane and the I2C-accessed register file. Captures every byte strobed out of the SPI slave into a first-word-fall-through FIFO and tracks per-transaction (CS frame) byte counts. The register file pops bytes and reads status through it, so SPI bursts are no longer lost to single-byte overwrite. Overflow/underflow are recorded as sticky flags.

## Interface
- DEPTH, 16: FIFO entries; power of two, 4..256
- WIDTH, 8: data width in bits
- AF_LEVEL, 12: almost_full asserts when level >= AF_LEVEL
- Ports:
- clk  in  1  100 MHz system clock
- rst_n  in  1  reset; asynchronous, active-low
- wr_valid  in  1  one-cycle strobe: byte completed by the SPI slave
- wr_data  in  WIDTH  received byte, valid with wr_valid
- spi_active  in  1  high while CS is asserted; already synchronous to clk
- rd_pop  in  1  register-file pop strobe
- rd_data  out  WIDTH  head entry (FWFT); 0 when empty
- flush  in  1  synchronous clear of FIFO contents
- sticky_clr  in  1  clears overflow and underflow
- level  out  $clog2(DEPTH)+1  entries held
- empty, full, almost_full  out  1  status
- overflow, underflow  out  1  sticky error flags
- frame_len  out  8  byte count of last completed frame, saturating at 255
- frame_done  out  1  one-cycle pulse when a frame ends

## Operation
- Storage: DEPTH x WIDTH array, read/write pointers with one extra wrap bit; level = wr_ptr - rd_ptr; pointers wrap modulo 2*DEPTH.
- Push accepted when wr_valid && (!full || rd_pop). Push when full and no pop: byte dropped, overflow <= 1.
- Pop accepted when rd_pop && !empty. Pop while empty: ignored, underflow <= 1 (even if a push arrives that same cycle; the push is still accepted).
- Simultaneous accepted push and pop: level unchanged, both pointers advance.
- flush: highest priority; pointers to 0, same-cycle push and pop discarded, no flags set. Sticky flags and frame state unaffected.
- sticky_clr clears both flags; a new overflow/underflow in the same cycle wins (flag stays 1).
- rd_data driven combinationally from mem[rd_ptr] when !empty, else 0.
- Frame tracking: internal count increments (saturating 255) on every wr_valid, accepted or dropped. Falling edge of spi_active (registered previous value 1, current 0): frame_len <= sat(count + wr_valid), frame_done = 1 for that cycle, count <= 0. Rising edge: count <= wr_valid (new frame). A zero-byte frame yields frame_len = 0 and still pulses frame_done.

## Timing
- Reset (async assert, release synchronous to clk): pointers 0, level 0, empty 1, full 0, almost_full 0, overflow 0, underflow 0, rd_data 0, frame_len 0, frame_done 0, count 0, spi_active history 0.
- All status outputs registered-state derived: push in cycle N -> level/empty/rd_data updated N+1.
- Pop in cycle N -> next entry on rd_data at N+1.
- frame_done asserted in the cycle after spi_active is first seen low; frame_len valid the same cycle and held until next frame end.
- Reset mid-burst: all contents and partial frame count discarded; no frame_done generated.

## Structure
- Package spi_fifo_pkg: default DEPTH/WIDTH/AF_LEVEL, and status bit positions (EMPTY=0, FULL=1, ALMOST_FULL=2, OVERFLOW=3, UNDERFLOW=4) used by the register file's FIFO status register.
- One sub-module: spi_frame_tracker (edge detect, saturating count, frame_len/frame_done); FIFO core stays in spi_rx_fifo.

## Test plan
- Reset, push 0xA5, 0x3C -> level 2, rd_data 0xA5 next cycle; pop -> rd_data 0x3C; pop -> empty 1, rd_data 0.
- Push 17 bytes into DEPTH=16 -> full 1, 17th byte dropped, overflow 1; sticky_clr -> overflow 0; contents 0..15 intact.
- Full FIFO, push 0x77 with pop same cycle -> level stays 16, 0x77 emerges as last entry; wrap pointer exercised over 40 pushes/pops.
- Empty FIFO, pop and push 0x11 same cycle -> underflow 1, level 1, rd_data 0x11.
- spi_active high, 300 strobes, low -> frame_done one cycle, frame_len 255; next frame 3 bytes -> frame_len 3.
- flush coincident with push, then async reset mid-frame -> level 0, no frame_done, all outputs at reset values.

Source files
------------

// File: rtl/spi_fifo_pkg.sv
// Shared definitions for the SPI receive FIFO and the register file that reads it.
// Defaults, status register bit positions and small helpers.
package spi_fifo_pkg;

    localparam int DEF_DEPTH    = 16;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_AF_LEVEL = 12;

    localparam int STATUS_W       = 5;
    localparam int ST_EMPTY       = 0;
    localparam int ST_FULL        = 1;
    localparam int ST_ALMOST_FULL = 2;
    localparam int ST_OVERFLOW    = 3;
    localparam int ST_UNDERFLOW   = 4;

    typedef struct packed {
        logic push;
        logic pop;
        logic ovf;
        logic unf;
    } fifo_op_t;

    typedef enum logic [1:0] {
        EDGE_NONE,
        EDGE_RISE,
        EDGE_FALL
    } cs_edge_e;

    function automatic logic [7:0] sat_add(
        input logic [7:0] a,
        input logic       b
    );
        logic [8:0] s;
        s = {1'b0, a} + {8'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    function automatic logic [STATUS_W-1:0] pack_status(
        input logic empty,
        input logic full,
        input logic almost_full,
        input logic overflow,
        input logic underflow
    );
        logic [STATUS_W-1:0] s;
        s                 = '0;
        s[ST_EMPTY]       = empty;
        s[ST_FULL]        = full;
        s[ST_ALMOST_FULL] = almost_full;
        s[ST_OVERFLOW]    = overflow;
        s[ST_UNDERFLOW]   = underflow;
        return s;
    endfunction

endpackage

// File: rtl/spi_rx_fifo_frame.sv
// CS frame tracker: counts strobes per chip-select frame and reports
// the saturated byte count with a one-cycle pulse when CS deasserts.
module spi_frame_tracker
    import spi_fifo_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_active,
    input  logic       wr_valid,
    output logic [7:0] frame_len,
    output logic       frame_done
);

    logic       active_q;
    logic [7:0] count;
    cs_edge_e   cs_edge;

    always_comb begin
        cs_edge = EDGE_NONE;
        if (active_q && !spi_active) begin
            cs_edge = EDGE_FALL;
        end else if (!active_q && spi_active) begin
            cs_edge = EDGE_RISE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            count      <= '0;
            frame_len  <= '0;
            frame_done <= 1'b0;
        end else begin
            active_q   <= spi_active;
            frame_done <= (cs_edge == EDGE_FALL);
            unique case (cs_edge)
                // The strobe coinciding with CS release still belongs to the frame.
                EDGE_FALL: begin
                    frame_len <= sat_add(count, wr_valid);
                    count     <= '0;
                end
                EDGE_RISE: begin
                    count <= {7'd0, wr_valid};
                end
                default: begin
                    count <= sat_add(count, wr_valid);
                end
            endcase
        end
    end

endmodule

// File: rtl/spi_rx_fifo.sv
// First-word-fall-through receive FIFO between the SPI slave and the
// register file, with sticky overflow/underflow and per-frame byte counts.
module spi_rx_fifo
    import spi_fifo_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int AF_LEVEL = DEF_AF_LEVEL
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     spi_active,
    input  logic                     rd_pop,
    output logic [WIDTH-1:0]         rd_data,
    input  logic                     flush,
    input  logic                     sticky_clr,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overflow,
    output logic                     underflow,
    output logic [7:0]               frame_len,
    output logic                     frame_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L   = LW'(AF_LEVEL);
    localparam logic [LW-1:0] ONE    = LW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    wr_ptr;
    logic [LW-1:0]    rd_ptr;
    logic [LW-1:0]    fill;
    fifo_op_t         op;

    assign fill        = wr_ptr - rd_ptr;
    assign level       = fill;
    assign empty       = (fill == '0);
    assign full        = (fill == FULL_L);
    assign almost_full = (fill >= AF_L);
    assign rd_data     = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Flush wins over everything in its cycle, including error detection.
    always_comb begin
        op      = '0;
        op.pop  = rd_pop && !empty;
        op.push = wr_valid && (!full || rd_pop);
        op.ovf  = wr_valid && full && !rd_pop;
        op.unf  = rd_pop && empty;
        if (flush) begin
            op = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (op.push) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (op.pop) begin
                rd_ptr <= rd_ptr + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (op.push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow && !sticky_clr) || op.ovf;
            underflow <= (underflow && !sticky_clr) || op.unf;
        end
    end

    spi_frame_tracker u_frame (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_active (spi_active),
        .wr_valid   (wr_valid),
        .frame_len  (frame_len),
        .frame_done (frame_done)
    );

endmodule
